// File: rtl/sum_accum.sv
// sum_accum: frames a valid/ready stream of adder sums through a 4-deep FIFO
// into saturating frame totals. Define SUM_ACCUM_MINMAX_EN for out_min/out_max.
module sum_accum #(
  parameter int IN_W      = 5,
  parameter int ACC_W     = 8,
  parameter int FRAME_LEN = 4,
  parameter int CNT_W     = $clog2(FRAME_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_sum,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_total,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
`ifdef SUM_ACCUM_MINMAX_EN
  ,
  output logic [IN_W-1:0]  out_min,
  output logic [IN_W-1:0]  out_max
`endif
);

  localparam int DEPTH = 4;
  localparam int SUM_W = ((ACC_W > IN_W) ? ACC_W : IN_W) + 1;

  typedef enum logic {
    S_ACCUM = 1'b0,
    S_HOLD  = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [IN_W-1:0]  r_mem [DEPTH];
  logic [1:0]       r_wptr;
  logic [1:0]       r_rptr;
  logic [2:0]       r_fcnt;

  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_count;
  logic             r_ovf;

  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_clear;
  logic             w_flush_go;
  logic             w_last;
  logic [IN_W-1:0]  w_head;
  logic [SUM_W-1:0] w_sum;
  logic             w_sat;
  logic [ACC_W-1:0] w_acc_nxt;

  assign w_full   = (r_fcnt == 3'd4);
  assign w_empty  = (r_fcnt == 3'd0);
  assign in_ready = !w_full;
  assign w_push   = in_valid && !w_full;
  assign w_head   = r_mem[r_rptr];

  // A flush only closes a frame that already holds samples.
  assign w_flush_go = flush && (r_count != '0);
  assign w_last     = (r_count == CNT_W'(FRAME_LEN - 1));

  // Widened add so the carry out of the accumulator is visible.
  assign w_sum     = SUM_W'(r_acc) + SUM_W'(w_head);
  assign w_sat     = |w_sum[SUM_W-1:ACC_W];
  assign w_acc_nxt = w_sat ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];

  // FIFO storage; pointers alone define validity, so no reset needed.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= in_sum;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_fcnt <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 2'd1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 2'd1;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_fcnt <= r_fcnt + 3'd1;
        2'b01:   r_fcnt <= r_fcnt - 3'd1;
        default: r_fcnt <= r_fcnt;
      endcase
    end
  end

  // Frame FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_ACCUM;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: close a frame on its last pop or a flush; reopen on accept.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_ACCUM: begin
        if (w_flush_go) begin
          w_state_nxt = S_HOLD;
        end else if (w_pop && w_last) begin
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          w_state_nxt = S_ACCUM;
        end
      end
      default: w_state_nxt = S_ACCUM;
    endcase
  end

  // FSM outputs: pop while accumulating, present result while holding.
  always_comb begin
    w_pop     = 1'b0;
    w_clear   = 1'b0;
    out_valid = 1'b0;
    unique case (r_state)
      S_ACCUM: begin
        w_pop = !w_empty && !w_flush_go;
      end
      S_HOLD: begin
        out_valid = 1'b1;
        w_clear   = out_ready;
      end
      default: begin
        w_pop = 1'b0;
      end
    endcase
  end

  // Saturating accumulator, sample count and sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc   <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else if (w_clear) begin
      r_acc   <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else if (w_pop) begin
      r_acc   <= w_acc_nxt;
      r_count <= r_count + CNT_W'(1);
      r_ovf   <= r_ovf | w_sat;
    end
  end

  assign out_total = r_acc;
  assign out_count = r_count;
  assign out_ovf   = r_ovf;

`ifdef SUM_ACCUM_MINMAX_EN
  logic [IN_W-1:0] r_min;
  logic [IN_W-1:0] r_max;

  // Per-frame extremes of popped samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_min <= '1;
      r_max <= '0;
    end else if (w_clear) begin
      r_min <= '1;
      r_max <= '0;
    end else if (w_pop) begin
      if (w_head < r_min) begin
        r_min <= w_head;
      end
      if (w_head > r_max) begin
        r_max <= w_head;
      end
    end
  end

  assign out_min = r_min;
  assign out_max = r_max;
`endif

endmodule

// File: tb/tb_sum_accum.sv
// tb_sum_accum: scoreboard bench for sum_accum (default and ACC_W=6 builds).
// Expected frames are queued by the stimulus and popped by a monitor.
module tb_sum_accum;

  localparam int IN_W  = 5;
  localparam int ACC_W = 8;
  localparam int CNT_W = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_sum;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_total;
  logic [CNT_W-1:0] out_count;
  logic             out_ovf;
`ifdef SUM_ACCUM_MINMAX_EN
  logic [IN_W-1:0]  out_min;
  logic [IN_W-1:0]  out_max;
`endif

  logic             v6;
  logic             rdy6;
  logic [IN_W-1:0]  s6;
  logic             flush6;
  logic             ov6;
  logic             ordy6;
  logic [5:0]       tot6;
  logic [CNT_W-1:0] cnt6;
  logic             ovf6;
`ifdef SUM_ACCUM_MINMAX_EN
  logic [IN_W-1:0]  min6;
  logic [IN_W-1:0]  max6;
`endif

  // out_ready is either the directed level or a per-cycle random bit.
  logic rnd;
  logic ordy_m;
  logic r_rand;
  assign out_ready = rnd ? r_rand : ordy_m;
  always @(negedge clk) r_rand <= 1'($urandom_range(1, 0));

  sum_accum #(.IN_W(IN_W), .ACC_W(ACC_W), .FRAME_LEN(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_sum(in_sum),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_total(out_total), .out_count(out_count), .out_ovf(out_ovf)
`ifdef SUM_ACCUM_MINMAX_EN
    , .out_min(out_min), .out_max(out_max)
`endif
  );

  sum_accum #(.IN_W(IN_W), .ACC_W(6), .FRAME_LEN(4)) dut6 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(v6), .in_ready(rdy6), .in_sum(s6),
    .flush(flush6),
    .out_valid(ov6), .out_ready(ordy6),
    .out_total(tot6), .out_count(cnt6), .out_ovf(ovf6)
`ifdef SUM_ACCUM_MINMAX_EN
    , .out_min(min6), .out_max(max6)
`endif
  );

  typedef struct {
    int tot;
    int cnt;
    int ovf;
    int mn;
    int mx;
  } exp_t;

  exp_t q[$];
  exp_t q6[$];
  int   total = 0;
  int   bad = 0;
  int   accepted = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: compare each new frame on its first valid cycle, then
  // require the presented values to stay put while it is held.
  logic             seen;
  logic [ACC_W-1:0] h_tot;
  logic [CNT_W-1:0] h_cnt;
  exp_t             e;
  always @(negedge clk) begin
    if (!rst_n) begin
      seen <= 1'b0;
    end else if (out_valid && !seen) begin
      seen  <= 1'b1;
      h_tot <= out_total;
      h_cnt <= out_count;
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_frame: got total %0d expected none",
                 out_total);
      end else begin
        e = q.pop_front();
        chk("frame_total", int'(out_total), e.tot);
        chk("frame_count", int'(out_count), e.cnt);
        chk("frame_ovf", int'(out_ovf), e.ovf);
`ifdef SUM_ACCUM_MINMAX_EN
        chk("frame_min", int'(out_min), e.mn);
        chk("frame_max", int'(out_max), e.mx);
`endif
      end
    end else if (out_valid) begin
      chk("hold_total", int'(out_total), int'(h_tot));
      chk("hold_count", int'(out_count), int'(h_cnt));
    end else begin
      seen <= 1'b0;
    end
  end

  logic seen6;
  exp_t e6;
  always @(negedge clk) begin
    if (!rst_n) begin
      seen6 <= 1'b0;
    end else if (ov6 && !seen6) begin
      seen6 <= 1'b1;
      if (q6.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_frame6: got total %0d expected none", tot6);
      end else begin
        e6 = q6.pop_front();
        chk("sat_total", int'(tot6), e6.tot);
        chk("sat_count", int'(cnt6), e6.cnt);
        chk("sat_ovf", int'(ovf6), e6.ovf);
`ifdef SUM_ACCUM_MINMAX_EN
        chk("sat_min", int'(min6), e6.mn);
        chk("sat_max", int'(max6), e6.mx);
`endif
      end
    end else if (!ov6) begin
      seen6 <= 1'b0;
    end
  end

  // Called at a falling edge; returns at the falling edge after the push.
  task automatic push(input int v);
    int n = 0;
    in_valid = 1'b1;
    in_sum   = v[IN_W-1:0];
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL push_timeout: got in_ready 0 expected 1");
    end else begin
      accepted++;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic push6(input int v);
    v6 = 1'b1;
    s6 = v[IN_W-1:0];
    @(negedge clk);
    v6 = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while ((q.size() != 0 || q6.size() != 0 || out_valid) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got %0d frames pending expected 0",
               nm, q.size() + q6.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  int vals[4];
  int sum;
  int k;
  int mn;
  int mx;
  int v;

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_sum   = '0;
    flush    = 1'b0;
    rnd      = 1'b0;
    ordy_m   = 1'b1;
    v6       = 1'b0;
    s6       = '0;
    flush6   = 1'b0;
    ordy6    = 1'b1;
    repeat (2) @(negedge clk);

    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_total", int'(out_total), 0);
    chk("rst_out_count", int'(out_count), 0);
    chk("rst_out_ovf", int'(out_ovf), 0);
`ifdef SUM_ACCUM_MINMAX_EN
    chk("rst_out_min", int'(out_min), 31);
    chk("rst_out_max", int'(out_max), 0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // Basic frame and last-push-to-valid latency.
    q.push_back('{31, 4, 0, 3, 12});
    vals = '{3, 7, 12, 9};
    foreach (vals[i]) push(vals[i]);
    chk("latency_pre", int'(out_valid), 0);
    @(negedge clk);
    chk("latency_valid", int'(out_valid), 1);
    wait_idle("basic");

    // Saturation on the narrow accumulator.
    q6.push_back('{63, 4, 1, 1, 31});
    vals = '{31, 31, 31, 1};
    foreach (vals[i]) push6(vals[i]);
    wait_idle("sat");

    // Backpressure: first frame held, FIFO fills, then drain.
    ordy_m   = 1'b0;
    accepted = 0;
    repeat (3) q.push_back('{4, 4, 0, 1, 1});
    fork
      begin
        for (int i = 0; i < 12; i++) push(1);
      end
    join_none
    repeat (15) @(negedge clk);
    chk("bp_in_ready", int'(in_ready), 0);
    chk("bp_accepted", accepted, 8);
    chk("bp_out_valid", int'(out_valid), 1);
    chk("bp_out_total", int'(out_total), 4);
    ordy_m = 1'b1;
    wait fork;
    wait_idle("drain");
    chk("drain_accepted", accepted, 12);

    // Flush of a partial frame, then a flush with nothing accumulated.
    q.push_back('{11, 2, 0, 5, 6});
    push(5);
    push(6);
    repeat (3) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_valid", int'(out_valid), 1);
    wait_idle("flush");
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("empty_flush_valid", int'(out_valid), 0);
      @(negedge clk);
    end

    // Reset mid-frame discards the partial frame.
    push(8);
    push(8);
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", int'(in_ready), 1);
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_out_total", int'(out_total), 0);
    chk("midrst_out_count", int'(out_count), 0);
    chk("midrst_out_ovf", int'(out_ovf), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    q.push_back('{10, 4, 0, 1, 4});
    vals = '{1, 2, 3, 4};
    foreach (vals[i]) push(vals[i]);
    wait_idle("post_rst");

    // Random samples with random backpressure.
    rnd = 1'b1;
    sum = 0;
    k   = 0;
    mn  = 31;
    mx  = 0;
    for (int i = 0; i < 200; i++) begin
      v   = int'($urandom_range(20, 0));
      sum = sum + v;
      k++;
      if (v < mn) mn = v;
      if (v > mx) mx = v;
      if (k == 4) begin
        q.push_back('{sum, 4, 0, mn, mx});
        sum = 0;
        k   = 0;
        mn  = 31;
        mx  = 0;
      end
      push(v);
    end
    rnd = 1'b0;
    if (k > 0) begin
      q.push_back('{sum, k, 0, mn, mx});
      repeat (10) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
    end
    wait_idle("random");

    chk("queue_empty", q.size(), 0);
    chk("queue6_empty", q6.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
